// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a framed byte stream into 16-bit imem writes
// and holds the core in reset until a frame with a good checksum has been loaded.
module imem_loader #(
    parameter int       MAX_WORDS      = 128,
    parameter bit [7:0] SYNC_BYTE      = 8'hA5,
    parameter int       TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic [15:0] imem_addr,
    output logic [15:0] imem_wdata,
    output logic        core_reset,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  words_loaded
);

    localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]     MAX_LEN  = 8'(MAX_WORDS);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA_HI,
        S_DATA_LO,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t         r_state;
    state_t         w_next_state;

    logic           r_in_ready;
    logic           r_we;
    logic [15:0]    r_addr;
    logic [15:0]    r_wdata;
    logic           r_core_reset;
    logic           r_busy;
    logic           r_done;
    logic           r_error;
    logic [7:0]     r_words;
    logic [7:0]     r_len;
    logic [7:0]     r_idx;
    logic [7:0]     r_chk;
    logic [7:0]     r_hi;
    logic [TW-1:0]  r_tmo;

    logic           w_accept;
    logic           w_in_frame;
    logic           w_len_ok;
    logic           w_timeout;

    assign w_accept   = in_valid & r_in_ready;
    assign w_in_frame = (r_state == S_LEN) || (r_state == S_DATA_HI) ||
                        (r_state == S_DATA_LO) || (r_state == S_CHECK);
    assign w_len_ok   = (in_data != 8'd0) && (in_data <= MAX_LEN);
    assign w_timeout  = w_in_frame && !w_accept && (r_tmo == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: next state defaults to the current state so no path through the case infers a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept && in_data == SYNC_BYTE) w_next_state = S_LEN;
            end
            S_LEN: begin
                if (w_accept) w_next_state = w_len_ok ? S_DATA_HI : S_ERROR;
            end
            S_DATA_HI: begin
                if (w_accept) w_next_state = S_DATA_LO;
            end
            S_DATA_LO: begin
                if (w_accept) w_next_state = ((r_idx + 8'd1) == r_len) ? S_CHECK : S_DATA_HI;
            end
            S_CHECK: begin
                if (w_accept) w_next_state = (in_data == r_chk) ? S_DONE : S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (w_accept && in_data == SYNC_BYTE) w_next_state = S_LEN;
            end
            default: w_next_state = S_IDLE;
        endcase
        if (w_timeout) w_next_state = S_ERROR;
    end

    // Status outputs are registered from the next state so they line up with the state register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_ready   <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_core_reset <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_words      <= '0;
            r_len        <= '0;
            r_idx        <= '0;
            r_chk        <= '0;
            r_hi         <= '0;
            r_tmo        <= '0;
        end else begin
            r_in_ready   <= 1'b1;
            r_we         <= 1'b0;
            r_busy       <= (w_next_state == S_LEN) || (w_next_state == S_DATA_HI) ||
                            (w_next_state == S_DATA_LO) || (w_next_state == S_CHECK);
            r_done       <= (w_next_state == S_DONE);
            r_error      <= (w_next_state == S_ERROR);
            r_core_reset <= (w_next_state != S_DONE);

            if (w_accept) begin
                r_tmo <= '0;
            end else if (w_in_frame) begin
                r_tmo <= r_tmo + TW'(1);
            end

            if (w_accept) begin
                unique case (r_state)
                    S_LEN: begin
                        if (w_len_ok) begin
                            r_len   <= in_data;
                            r_idx   <= '0;
                            r_chk   <= '0;
                            r_words <= '0;
                        end
                    end
                    S_DATA_HI: begin
                        r_hi  <= in_data;
                        r_chk <= r_chk ^ in_data;
                    end
                    S_DATA_LO: begin
                        r_chk   <= r_chk ^ in_data;
                        r_we    <= 1'b1;
                        r_addr  <= {7'd0, r_idx, 1'b0};
                        r_wdata <= {r_hi, in_data};
                        r_idx   <= r_idx + 8'd1;
                        r_words <= r_idx + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign core_reset   = r_core_reset;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected imem writes go to a scoreboard queue when
// the frame is driven and are popped by a monitor as write pulses appear.
module tb_imem_loader;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  words_loaded;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];

    imem_loader #(.MAX_WORDS(128), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset   (core_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write monitor: each pulse must match the oldest expected {addr, wdata}.
    always @(negedge clk) begin
        if (reset === 1'b1 && imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {imem_addr, imem_wdata}, 32'hFFFF_FFFF);
            end else begin
                check("imem_write", {imem_addr, imem_wdata}, exp_q.pop_front());
            end
        end
    end

    task automatic send_bytes(input logic [7:0] b[]);
        foreach (b[i]) begin
            in_data  = b[i];
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // 1: reset values, then release
        #23;
        check("rst_core_reset", core_reset, 1);
        check("rst_imem_we", imem_we, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        reset = 1'b1;
        idle(2);
        check("rel_in_ready", in_ready, 1);
        check("rel_core_reset", core_reset, 1);

        // 2: good two-word frame, back to back
        exp_q.push_back({16'h0000, 16'h1234});
        exp_q.push_back({16'h0002, 16'hABCD});
        send_bytes('{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD});
        check("t2_done_before_chk", done, 0);
        check("t2_busy", busy, 1);
        send_bytes('{8'h40});
        check("t2_done", done, 1);
        check("t2_core_reset", core_reset, 0);
        check("t2_busy_after", busy, 0);
        check("t2_words", words_loaded, 2);
        check("t2_writes_seen", exp_q.size(), 0);

        // 3: same frame with bad checksum
        exp_q.push_back({16'h0000, 16'h1234});
        exp_q.push_back({16'h0002, 16'hABCD});
        send_bytes('{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41});
        check("t3_error", error, 1);
        check("t3_done", done, 0);
        check("t3_core_reset", core_reset, 1);
        check("t3_writes_seen", exp_q.size(), 0);

        // 4: illegal lengths (0 and MAX_WORDS+1)
        send_bytes('{8'hA5});
        check("t4_error_cleared", error, 0);
        check("t4_busy", busy, 1);
        send_bytes('{8'h00});
        check("t4_len0_error", error, 1);
        send_bytes('{8'hA5, 8'h81});
        check("t4_len129_error", error, 1);
        check("t4_busy_after", busy, 0);

        // sync value inside a frame is data: A5 01 A5 00 chk=A5
        exp_q.push_back({16'h0000, 16'hA500});
        send_bytes('{8'hA5, 8'h01, 8'hA5, 8'h00, 8'hA5});
        check("sync_as_data_done", done, 1);
        check("sync_as_data_writes", exp_q.size(), 0);

        // 5: timeout mid-frame, then recovery
        send_bytes('{8'hA5, 8'h02, 8'h12});
        idle(TMO - 2);
        check("t5_busy_pre_tmo", busy, 1);
        check("t5_error_pre_tmo", error, 0);
        idle(4);
        check("t5_tmo_error", error, 1);
        check("t5_tmo_busy", busy, 0);
        check("t5_tmo_core_reset", core_reset, 1);
        exp_q.push_back({16'h0000, 16'h5566});
        send_bytes('{8'hA5, 8'h01, 8'h55, 8'h66, 8'h33});
        check("t5_done", done, 1);
        check("t5_words", words_loaded, 1);
        check("t5_core_reset", core_reset, 0);

        // 6: new sync after done, then reset mid-data
        send_bytes('{8'hA5});
        check("t6_done_cleared", done, 0);
        check("t6_core_reset", core_reset, 1);
        exp_q.push_back({16'h0000, 16'hAABB});
        send_bytes('{8'h02, 8'hAA, 8'hBB, 8'hCC});
        check("t6_words_mid", words_loaded, 1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_core_reset", core_reset, 1);
        check("t6_rst_words", words_loaded, 0);
        check("t6_rst_addr", imem_addr, 0);
        check("t6_rst_wdata", imem_wdata, 0);
        check("t6_rst_in_ready", in_ready, 0);
        check("t6_writes_seen", exp_q.size(), 0);
        #10;
        reset = 1'b1;
        idle(2);
        check("t6_rel_in_ready", in_ready, 1);
        check("t6_rel_state_idle", {busy, done, error}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
